// File: rtl/fifo_arb_pkg.sv
// ----------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared definitions for the round-robin FIFO write-port arbiter.
//   - arb_state_e : two-state arbiter encoding (ST_IDLE, ST_BURST)
//   - id_width()  : requester tag width, never less than one bit
// ----------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    function automatic int id_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// ----------------------------------------------------------------------------
// rr_priority_pick
//   Combinational rotating priority encoder. Searches req starting at
//   last+1 and wrapping modulo NUM_REQ, so the most recently granted
//   requester has the lowest priority.
// Ports
//   req      in   NUM_REQ    request vector
//   last     in   ID_WIDTH   index of the last granted requester
//   pick     out  ID_WIDTH   first requester found after last (0 if none)
//   any_req  out  1          at least one request bit set
// ----------------------------------------------------------------------------
module rr_priority_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last,
    output logic [ID_WIDTH-1:0] pick,
    output logic                any_req
);

    logic [ID_WIDTH-1:0] idx;

    // Walk the search order backwards so the closest match to last+1 is the
    // final assignment and therefore wins. The modulo keeps indices below
    // NUM_REQ even when NUM_REQ is not a power of two.
    always_comb begin
        pick = '0;
        idx  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = ID_WIDTH'((int'(last) + i) % NUM_REQ);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/fifo_wr_rr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_rr_arbiter
//   Shares one synchronous FIFO write port among NUM_REQ valid/ready
//   producers. A producer is granted for up to MAX_BURST beats; every word is
//   written as {grant_id, payload}. Each grant is followed by one IDLE
//   arbitration cycle. No write is issued while the FIFO reports full.
// Ports
//   clk             in   1                    clock
//   rst_n           in   1                    async active-low reset
//   req_valid_i     in   NUM_REQ              per-requester valid
//   req_data_i      in   NUM_REQ*DATA_WIDTH   payloads, req k at [k*DW +: DW]
//   req_ready_o     out  NUM_REQ              per-requester ready
//   fifo_full_i     in   1                    FIFO full flag
//   fifo_wr_en_o    out  1                    FIFO write enable
//   fifo_wr_data_o  out  ID_WIDTH+DATA_WIDTH  {grant_id, payload}
//   grant_valid_o   out  1                    high while a grant is active
//   grant_id_o      out  ID_WIDTH             current / last granted requester
//   burst_cnt_o     out  BCNT_WIDTH           beats accepted in this grant
// ----------------------------------------------------------------------------
module fifo_wr_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4,
    parameter int ID_WIDTH   = id_width(NUM_REQ),
    parameter int BCNT_WIDTH = $clog2(MAX_BURST + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
    input  logic                           fifo_full_i,
    output logic                           fifo_wr_en_o,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_wr_data_o,
    output logic                           grant_valid_o,
    output logic [ID_WIDTH-1:0]            grant_id_o,
    output logic [BCNT_WIDTH-1:0]          burst_cnt_o
);

    arb_state_e              state, state_nxt;
    logic [ID_WIDTH-1:0]     last_grant, last_nxt, grant_nxt;
    logic [BCNT_WIDTH-1:0]   cnt_nxt;
    logic [ID_WIDTH-1:0]     pick;
    logic                    any_req;
    logic                    g_valid;
    logic [DATA_WIDTH-1:0]   g_data;

    rr_priority_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req     (req_valid_i),
        .last    (last_grant),
        .pick    (pick),
        .any_req (any_req)
    );

    // Constant-index mux of the granted requester's valid and payload.
    always_comb begin
        g_valid = 1'b0;
        g_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id_o == ID_WIDTH'(k)) begin
                g_valid = req_valid_i[k];
                g_data  = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign fifo_wr_data_o = {grant_id_o, g_data};
    assign grant_valid_o  = (state == ST_BURST);

    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant_id_o;
        last_nxt     = last_grant;
        cnt_nxt      = burst_cnt_o;
        req_ready_o  = '0;
        fifo_wr_en_o = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    grant_nxt = pick;
                    last_nxt  = pick;
                    cnt_nxt   = '0;
                    state_nxt = ST_BURST;
                end
            end
            ST_BURST: begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    req_ready_o[k] = (grant_id_o == ID_WIDTH'(k)) && !fifo_full_i;
                end
                fifo_wr_en_o = g_valid && !fifo_full_i;
                // A dropped valid forfeits the grant even while stalled on full;
                // a full FIFO with valid held simply freezes the burst.
                if (!g_valid) begin
                    state_nxt = ST_IDLE;
                end else if (!fifo_full_i) begin
                    cnt_nxt = burst_cnt_o + BCNT_WIDTH'(1);
                    if (burst_cnt_o == BCNT_WIDTH'(MAX_BURST - 1)) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // last_grant resets to the top index so requester 0 wins the first search.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            grant_id_o  <= '0;
            last_grant  <= ID_WIDTH'(NUM_REQ - 1);
            burst_cnt_o <= '0;
        end else begin
            state       <= state_nxt;
            grant_id_o  <= grant_nxt;
            last_grant  <= last_nxt;
            burst_cnt_o <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_rr_arbiter
//   Bench for fifo_wr_rr_arbiter. A main instance (4 requesters, burst 4) is
//   checked cycle by cycle against a behavioural arbitration model; a second
//   instance (3 requesters, burst 1) covers the non-power-of-two wrap. The
//   FIFO is represented by a depth-8 queue that drives the full flag.
// ----------------------------------------------------------------------------
module tb_fifo_wr_rr_arbiter;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int MB    = 4;
    localparam int IDW   = 2;
    localparam int BW    = 3;
    localparam int WW    = IDW + DW;
    localparam int N3    = 3;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [WW-1:0]   fifo_wr_data;
    logic            grant_valid;
    logic [IDW-1:0]  grant_id;
    logic [BW-1:0]   burst_cnt;

    logic [N3-1:0]    req_valid3;
    logic [N3*DW-1:0] req_data3;
    logic [N3-1:0]    req_ready3;
    logic             fifo_full3;
    logic             fifo_wr_en3;
    logic [WW-1:0]    fifo_wr_data3;
    logic             grant_valid3;
    logic [IDW-1:0]   grant_id3;
    logic [0:0]       burst_cnt3;

    always #5 clk = ~clk;

    fifo_wr_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_data_i     (req_data),
        .req_ready_o    (req_ready),
        .fifo_full_i    (fifo_full),
        .fifo_wr_en_o   (fifo_wr_en),
        .fifo_wr_data_o (fifo_wr_data),
        .grant_valid_o  (grant_valid),
        .grant_id_o     (grant_id),
        .burst_cnt_o    (burst_cnt)
    );

    fifo_wr_rr_arbiter #(.NUM_REQ(N3), .DATA_WIDTH(DW), .MAX_BURST(1)) dut3 (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid3),
        .req_data_i     (req_data3),
        .req_ready_o    (req_ready3),
        .fifo_full_i    (fifo_full3),
        .fifo_wr_en_o   (fifo_wr_en3),
        .fifo_wr_data_o (fifo_wr_data3),
        .grant_valid_o  (grant_valid3),
        .grant_id_o     (grant_id3),
        .burst_cnt_o    (burst_cnt3)
    );

    // Behavioural model: who holds the grant, how many beats so far.
    bit             m_busy;
    int             m_g, m_cnt, m_last;
    int             seq[N];
    logic [DW-1:0]  base[N];
    logic [WW-1:0]  fifo_q[$], exp_q[$], wr_log[$];
    bit             rd_req;
    int             checks, errors;
    logic [44:0]    obs_vec, exp_vec;
    logic [41:0]    obs3;

    function automatic int pick_model(input logic [N-1:0] v, input int last);
        for (int i = 1; i <= N; i++) begin
            if (v[(last + i) % N]) return (last + i) % N;
        end
        return 0;
    endfunction

    task automatic drive_data();
        for (int k = 0; k < N; k++) req_data[k*DW +: DW] = base[k] + DW'(seq[k]);
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_g = 0; m_cnt = 0; m_last = N - 1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = '0; req_valid3 = '0; rd_req = 1'b0;
        fifo_full = 1'b0; fifo_full3 = 1'b0;
        model_reset();
        fifo_q.delete(); exp_q.delete(); wr_log.delete();
        for (int k = 0; k < N; k++) begin
            seq[k] = 0; base[k] = $urandom;
        end
        drive_data();
        req_data3 = {$urandom, $urandom, $urandom};
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: sample just before the rising edge, advance FIFO and model on
    // the edge, then present new payloads/full at the falling edge.
    task automatic cycle();
        logic          s_wr;
        logic [WW-1:0] s_data;
        bit            exp_wr;
        int            beat_k;
        #4;
        exp_wr  = m_busy && req_valid[m_g] && !fifo_full;
        s_wr    = fifo_wr_en;
        s_data  = fifo_wr_data;
        obs_vec = {grant_valid, grant_id, burst_cnt, req_ready, fifo_wr_en,
                   fifo_wr_en ? fifo_wr_data : WW'(0)};
        exp_vec = {m_busy, IDW'(m_g), BW'(m_cnt),
                   (m_busy && !fifo_full) ? N'(1 << m_g) : N'(0), exp_wr,
                   exp_wr ? {IDW'(m_g), base[m_g] + DW'(seq[m_g])} : WW'(0)};
        obs3    = {grant_valid3, grant_id3, burst_cnt3, req_ready3, fifo_wr_en3,
                   fifo_wr_en3 ? fifo_wr_data3 : WW'(0)};
        @(posedge clk);
        if (rd_req && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        rd_req = 1'b0;
        if (s_wr) begin
            fifo_q.push_back(s_data);
            wr_log.push_back(s_data);
        end
        beat_k = -1;
        if (!m_busy) begin
            if (|req_valid) begin
                m_g = pick_model(req_valid, m_last);
                m_last = m_g; m_cnt = 0; m_busy = 1'b1;
            end
        end else if (!req_valid[m_g]) begin
            m_busy = 1'b0;
        end else if (!fifo_full) begin
            exp_q.push_back({IDW'(m_g), base[m_g] + DW'(seq[m_g])});
            beat_k = m_g;
            m_cnt++;
            if (m_cnt == MB) m_busy = 1'b0;
        end
        @(negedge clk);
        if (beat_k >= 0) seq[beat_k]++;
        drive_data();
        fifo_full = (fifo_q.size() >= DEPTH);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({grant_valid, grant_id, burst_cnt, req_ready, fifo_wr_en} !== 11'b0) begin
            errors++;
            $display("FAIL reset_main: got %h expected 0",
                     {grant_valid, grant_id, burst_cnt, req_ready, fifo_wr_en});
        end
        checks++;
        if ({grant_valid3, grant_id3, burst_cnt3, req_ready3, fifo_wr_en3} !== 8'b0) begin
            errors++;
            $display("FAIL reset_dut3: got %h expected 0",
                     {grant_valid3, grant_id3, burst_cnt3, req_ready3, fifo_wr_en3});
        end
        apply_reset();
        for (int c = 0; c < 3; c++) begin
            cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL reset_idle c%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_single_req();
        logic [9:0] gv_trace;
        apply_reset();
        base[2] = 32'hA0;
        drive_data();
        gv_trace = '0;
        for (int c = 0; c < 10; c++) begin
            req_valid = (seq[2] < 6) ? 4'b0100 : 4'b0000;
            cycle();
            gv_trace[c] = obs_vec[44];
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL single c%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
        end
        checks++;
        if (gv_trace !== 10'b0111011110) begin
            errors++;
            $display("FAIL single_grant_trace: got %b expected 0111011110", gv_trace);
        end
        checks++;
        if (fifo_q.size() != 6) begin
            errors++;
            $display("FAIL single_fifo_size: got %0d expected 6", fifo_q.size());
        end
        for (int i = 0; i < 6 && i < fifo_q.size(); i++) begin
            checks++;
            if (fifo_q[i] !== {2'd2, 32'hA0 + 32'(i)}) begin
                errors++;
                $display("FAIL single_fifo[%0d]: got %h expected %h", i, fifo_q[i],
                         {2'd2, 32'hA0 + 32'(i)});
            end
        end
    endtask

    task automatic test_all_valid();
        bit ok;
        apply_reset();
        req_valid = '1;
        for (int c = 0; c < 25; c++) begin
            rd_req = 1'b1;
            cycle();
            ok = (obs_vec[44] === ((c % 5) != 0)) &&
                 (((c % 5) == 0) || (obs_vec[43:39] === {IDW'((c / 5) % N), BW'((c % 5) - 1)}));
            checks++;
            if (!ok || obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL all_valid c%0d: got %h model %h", c, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_fifo_full();
        apply_reset();
        for (int i = 0; i < DEPTH - 1; i++) begin
            fifo_q.push_back(WW'(i)); exp_q.push_back(WW'(i));
        end
        for (int c = 0; c < 20; c++) begin
            req_valid = (seq[0] < MB) ? 4'b0001 : 4'b0000;
            rd_req = (c >= 5);
            cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL full c%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
            if (c >= 2 && c <= 5) begin
                checks++;
                if ({obs_vec[44], obs_vec[41:39], obs_vec[38:34]} !== {1'b1, 3'd1, 5'b0}) begin
                    errors++;
                    $display("FAIL full_stall c%0d: gv/cnt/ready/wr got %b expected 1_001_00000",
                             c, {obs_vec[44], obs_vec[41:39], obs_vec[38:34]});
                end
            end
        end
        checks++;
        if (wr_log.size() != MB) begin
            errors++;
            $display("FAIL full_beats: got %0d expected %0d", wr_log.size(), MB);
        end
        for (int j = 0; j < MB && j < wr_log.size(); j++) begin
            checks++;
            if (wr_log[j] !== {2'd0, base[0] + 32'(j)}) begin
                errors++;
                $display("FAIL full_data[%0d]: got %h expected %h", j, wr_log[j],
                         {2'd0, base[0] + 32'(j)});
            end
        end
    endtask

    task automatic test_drop();
        logic [N-1:0] masks[4] = '{4'b1100, 4'b1001, 4'b0011, 4'b0010};
        int           want[4]  = '{2, 3, 0, 1};
        for (int s = 0; s < 4; s++) begin
            apply_reset();
            for (int c = 0; c < 6; c++) begin
                if (c < 3)       req_valid = 4'b0010;
                else if (c == 3) req_valid = masks[s] & 4'b1101;
                else             req_valid = masks[s];
                cycle();
                checks++;
                if (obs_vec !== exp_vec) begin
                    errors++;
                    $display("FAIL drop s%0d c%0d: got %h expected %h", s, c, obs_vec, exp_vec);
                end
                if (c == 3) begin
                    checks++;
                    if ({obs_vec[44], obs_vec[41:39], obs_vec[34]} !== {1'b1, 3'd2, 1'b0}) begin
                        errors++;
                        $display("FAIL drop_release s%0d: gv/cnt/wr got %b expected 1_010_0",
                                 s, {obs_vec[44], obs_vec[41:39], obs_vec[34]});
                    end
                end
                if (c == 5) begin
                    checks++;
                    if (obs_vec[44:42] !== {1'b1, IDW'(want[s])}) begin
                        errors++;
                        $display("FAIL drop_next s%0d: gv/id got %b expected 1/%0d",
                                 s, obs_vec[44:42], want[s]);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req_valid = '1;
        for (int c = 0; c < 3; c++) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({grant_valid, grant_id, burst_cnt, req_ready, fifo_wr_en} !== 11'b0) begin
            errors++;
            $display("FAIL reset_mid_async: got %h expected 0",
                     {grant_valid, grant_id, burst_cnt, req_ready, fifo_wr_en});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (fifo_q.size() != 2) begin
            errors++;
            $display("FAIL reset_mid_fifo: got %0d entries expected 2", fifo_q.size());
        end
        for (int c = 0; c < 3; c++) begin
            cycle();
            checks++;
            if (obs_vec !== exp_vec || (c == 1 && obs_vec[44:42] !== 3'b100)) begin
                errors++;
                $display("FAIL reset_mid c%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_rr3();
        logic [41:0] e3;
        int          id;
        apply_reset();
        req_valid3 = '1;
        for (int c = 0; c < 12; c++) begin
            cycle();
            if (c % 2 == 1) begin
                id = (c / 2) % N3;
                e3 = {1'b1, IDW'(id), 1'b0, N3'(1 << id), 1'b1,
                      IDW'(id), req_data3[id*DW +: DW]};
            end else begin
                id = (c == 0) ? 0 : ((c / 2) - 1) % N3;
                e3 = {1'b0, IDW'(id), (c != 0), 3'b000, 1'b0, WW'(0)};
            end
            checks++;
            if (obs3 !== e3 || grant_id3 > 2'd2) begin
                errors++;
                $display("FAIL rr3 c%0d: got %h expected %h", c, obs3, e3);
            end
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) req_valid[k] = ($urandom_range(0, 3) != 0);
            rd_req = ($urandom_range(0, 2) != 0);
            cycle();
            checks++;
            if (obs_vec !== exp_vec) begin
                errors++;
                $display("FAIL random c%0d: got %h expected %h", c, obs_vec, exp_vec);
            end
        end
        checks++;
        if (fifo_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_fifo_size: got %0d expected %0d", fifo_q.size(), exp_q.size());
        end
        for (int i = 0; i < fifo_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (fifo_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_fifo[%0d]: got %h expected %h", i, fifo_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b1; req_valid = '0; req_valid3 = '0;
        req_data = '0; req_data3 = '0;
        fifo_full = 1'b0; fifo_full3 = 1'b0; rd_req = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_req();
        test_all_valid();
        test_fifo_full();
        test_drop();
        test_reset_mid();
        test_rr3();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
